// File: rtl/wb_uart_tx_if.sv
// Wishbone classic slave bundle for the UART transmitter.
// Signal names follow the slave's view (_i into the slave, _o out).
interface wb_uart_tx_if;
  logic        stb_i;
  logic        cyc_i;
  logic [31:0] adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic        we_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport master (
    output stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
// Registers: DATA (0x0), STATUS (0x4), DIV (0x8).
module wb_uart_tx #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_1000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd104
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_uart_tx_if.slave wb,
  output logic        tx_o
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [15:0] cur_div_q, cur_div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [15:0] div_q, div_d;
  logic        hold_q, hold_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rty_q, rty_d;
  logic [31:0] dat_q, dat_d;

  logic        sel_now, req;
  logic [1:0]  off;
  logic        bad_adr, is_data, is_stat, is_div;
  logic        full, empty, busy;
  logic        push, pop, last;
  logic [15:0] wr_div;
  logic        unused;

  assign sel_now = wb.stb_i & wb.cyc_i &
                   (wb.adr_i[31:4] == BASE_ADDRESS[31:4]);
  // One response per strobe: only the first selected cycle is served.
  assign req     = sel_now & ~hold_q;
  assign off     = wb.adr_i[3:2];
  assign bad_adr = (|wb.adr_i[1:0]) | (off == 2'd3);
  assign is_data = ~bad_adr & (off == 2'd0);
  assign is_stat = ~bad_adr & (off == 2'd1);
  assign is_div  = ~bad_adr & (off == 2'd2);

  assign full   = (cnt_q == 3'd4);
  assign empty  = (cnt_q == 3'd0);
  assign busy   = (state_q != IDLE);
  assign wr_div = (wb.dat_i[15:0] < 16'd2) ? 16'd2 : wb.dat_i[15:0];
  assign unused = ^{wb.dat_i[31:16], wb.sel_i[3:2]};

  always_comb begin
    ack_d  = 1'b0;
    err_d  = 1'b0;
    rty_d  = 1'b0;
    dat_d  = 32'h0;
    push   = 1'b0;
    div_d  = div_q;
    hold_d = sel_now;
    if (req) begin
      unique case (1'b1)
        bad_adr: err_d = 1'b1;
        is_data: begin
          if (wb.we_i && wb.sel_i[0]) begin
            rty_d = full;
            ack_d = ~full;
            push  = ~full;
          end else begin
            ack_d = 1'b1;
          end
        end
        is_stat: begin
          ack_d = 1'b1;
          if (!wb.we_i) begin
            dat_d = {29'h0, busy, empty, full};
          end
        end
        is_div: begin
          ack_d = 1'b1;
          if (wb.we_i) begin
            if (wb.sel_i[1:0] == 2'b11) begin
              div_d = wr_div;
            end
          end else begin
            dat_d = {16'h0, div_q};
          end
        end
        default: ;
      endcase
    end
  end

  assign last = (tick_q == cur_div_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 16'd1;
    cur_div_d = cur_div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        tick_d = 16'd0;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rptr_q];
          cur_div_d = div_q;
          state_d   = START;
        end
      end
      START: begin
        if (last) begin
          tick_d    = 16'd0;
          cur_div_d = div_q;
          idx_d     = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (last) begin
          tick_d    = 16'd0;
          cur_div_d = div_q;
          shift_d   = {1'b0, shift_q[7:1]};
          idx_d     = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (last) begin
          tick_d    = 16'd0;
          cur_div_d = div_q;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line driven from the current state, so it lags the FSM by a cycle.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == START) begin
      tx_d = 1'b0;
    end else if (state_q == DATA) begin
      tx_d = shift_q[0];
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = wb.dat_i[7:0];
      wptr_d        = wptr_q + 2'd1;
    end
    if (pop) begin
      rptr_d = rptr_q + 2'd1;
    end
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tick_q    <= 16'd0;
      cur_div_q <= CLKS_PER_BIT;
      idx_q     <= 3'd0;
      shift_q   <= 8'h0;
      tx_q      <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h0;
      end
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
      cnt_q     <= 3'd0;
      div_q     <= CLKS_PER_BIT;
      hold_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      dat_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      cur_div_q <= cur_div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      dat_q     <= dat_d;
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.rty_o = rty_q;
  assign wb.dat_o = dat_q;
  assign tx_o     = tx_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Randomised bench for wb_uart_tx against a queue-based line model.
// Directed literal checks pin the model's key timings and values.
module tb_wb_uart_tx;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  wb_uart_tx_if bus ();

  wb_uart_tx dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus),
    .tx_o  (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending bytes, and the per-cycle line values still to come.
  byte unsigned fq[$];
  bit           lq[$];
  int           div_m;
  bit           prev_sel;
  bit           mvalid = 1'b0;
  logic         exp_ack, exp_err, exp_rty, exp_tx;
  logic [31:0]  exp_dat;
  bit           m_sel, full_pre, empty_pre, busy_pre;
  byte unsigned cur;
  logic [31:0]  a_m;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      lq.delete();
      div_m    = 104;
      prev_sel = 1'b0;
      exp_ack  = 1'b0;
      exp_err  = 1'b0;
      exp_rty  = 1'b0;
      exp_dat  = 32'h0;
      exp_tx   = 1'b1;
      mvalid   = 1'b1;
    end else begin
      full_pre  = (fq.size() == 4);
      empty_pre = (fq.size() == 0);
      busy_pre  = (lq.size() != 0);
      exp_tx = (lq.size() != 0) ? lq.pop_front() : 1'b1;
      if (lq.size() == 0 && fq.size() != 0) begin
        cur = fq.pop_front();
        for (int i = 0; i < 10; i++) begin
          bit v;
          v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : cur[i-1];
          repeat (div_m) lq.push_back(v);
        end
      end
      a_m     = bus.adr_i;
      m_sel   = bus.stb_i && bus.cyc_i && ((a_m >> 4) == (BASE >> 4));
      exp_ack = 1'b0;
      exp_err = 1'b0;
      exp_rty = 1'b0;
      exp_dat = 32'h0;
      if (m_sel && !prev_sel) begin
        if ((a_m & 32'hF) == 32'hC || (a_m & 32'h3) != 0) begin
          exp_err = 1'b1;
        end else if ((a_m & 32'hF) == 32'h0) begin
          if (bus.we_i && bus.sel_i[0]) begin
            if (full_pre) exp_rty = 1'b1;
            else begin
              fq.push_back(bus.dat_i[7:0]);
              exp_ack = 1'b1;
            end
          end else exp_ack = 1'b1;
        end else if ((a_m & 32'hF) == 32'h4) begin
          exp_ack = 1'b1;
          if (!bus.we_i)
            exp_dat = {29'h0, busy_pre, empty_pre, full_pre};
        end else begin
          exp_ack = 1'b1;
          if (!bus.we_i) exp_dat = 32'(div_m);
          else if (bus.sel_i[1:0] == 2'b11)
            div_m = (bus.dat_i[15:0] < 2) ? 2 : int'(bus.dat_i[15:0]);
        end
      end
      prev_sel = m_sel;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("cyc_ack", 32'(bus.ack_o), 32'(exp_ack));
      chk("cyc_err", 32'(bus.err_o), 32'(exp_err));
      chk("cyc_rty", 32'(bus.rty_o), 32'(exp_rty));
      chk("cyc_dat", bus.dat_o, exp_dat);
      chk("cyc_tx", 32'(tx), 32'(exp_tx));
    end
  end

  logic tx_log[$];
  bit   cap = 1'b0;

  always @(negedge clk) begin
    if (cap) tx_log.push_back(tx);
  end

  logic        r_ack, r_err, r_rty;
  logic [31:0] r_dat;

  task automatic xact(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input int hold);
    bus.adr_i = a;
    bus.we_i  = w;
    bus.dat_i = d;
    bus.sel_i = s;
    bus.stb_i = 1'b1;
    bus.cyc_i = 1'b1;
    @(posedge clk);
    #1;
    r_ack = bus.ack_o;
    r_err = bus.err_o;
    r_rty = bus.rty_o;
    r_dat = bus.dat_o;
    repeat (hold - 1) @(posedge clk);
    if (hold > 1) #1;
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
    bus.we_i  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    xact(BASE + off, 1'b1, d, 4'hF, 1);
  endtask

  task automatic rd(input logic [31:0] off);
    xact(BASE + off, 1'b0, 32'h0, 4'hF, 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input logic [7:0] b, input int d,
                             input string nm);
    int f;
    logic e;
    f = -1;
    foreach (tx_log[i]) if (f < 0 && tx_log[i] == 1'b0) f = i;
    chk({nm, "_fall"}, 32'(f), 32'd3);
    if (f >= 0 && tx_log.size() > f + 10 * d) begin
      for (int k = 0; k < 10 * d; k++) begin
        e = (k < d) ? 1'b0 : (k >= 9 * d) ? 1'b1 : b[k/d-1];
        chk({nm, "_bit"}, 32'(tx_log[f+k]), 32'(e));
      end
      chk({nm, "_end"}, 32'(tx_log[f+10*d]), 32'd1);
    end else begin
      chk({nm, "_len"}, 32'(tx_log.size()), 32'(10 * d + 4));
    end
  endtask

  int acks, zeros;

  initial begin
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 32'h0;
    bus.sel_i = 4'h0;
    bus.dat_i = 32'h0;
    wait_cyc(3);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);

    rd(32'h4);
    chk("rst_status", r_dat, 32'h2);
    chk("rst_status_ack", 32'(r_ack), 32'd1);
    rd(32'h8);
    chk("rst_div", r_dat, 32'h68);
    rd(32'h0);
    chk("data_rd", r_dat, 32'h0);

    wr(32'h8, 32'h4);
    chk("div_wr_ack", 32'(r_ack), 32'd1);
    xact(BASE + 32'h8, 1'b1, 32'h9, 4'b0001, 1);
    rd(32'h8);
    chk("div_partial", r_dat, 32'h4);

    tx_log.delete();
    cap = 1'b1;
    wr(32'h0, 32'h55);
    chk("w55_ack", 32'(r_ack), 32'd1);
    chk("w55_rty", 32'(r_rty), 32'd0);
    rd(32'h4);
    chk("busy_status", r_dat, 32'h6);
    wait_cyc(45);
    cap = 1'b0;
    check_frame(8'h55, 4, "f55");
    rd(32'h4);
    chk("idle_status", r_dat, 32'h2);

    for (int i = 1; i <= 5; i++) begin
      wr(32'h0, 32'(i));
      chk("burst_ack", 32'(r_ack), 32'd1);
    end
    wr(32'h0, 32'h6);
    chk("full_rty", 32'(r_rty), 32'd1);
    chk("full_ack", 32'(r_ack), 32'd0);
    rd(32'h4);
    chk("full_status", r_dat, 32'h5);
    xact(BASE, 1'b1, 32'h77, 4'b1110, 1);
    chk("nosel_ack", 32'(r_ack), 32'd1);
    wait_cyc(230);

    rd(32'hC);
    chk("err_c", 32'(r_err), 32'd1);
    chk("err_c_ack", 32'(r_ack), 32'd0);
    wr(32'h2, 32'hAB);
    chk("err_mis", 32'(r_err), 32'd1);
    xact(32'h4000_2000, 1'b0, 32'h0, 4'hF, 1);
    chk("unmap_resp", {29'h0, r_ack, r_err, r_rty}, 32'h0);
    chk("unmap_dat", r_dat, 32'h0);
    rd(32'h4);
    chk("err_nochg", r_dat, 32'h2);

    wr(32'h8, 32'h0);
    rd(32'h8);
    chk("div_min", r_dat, 32'h2);
    tx_log.delete();
    cap = 1'b1;
    wr(32'h0, 32'hA5);
    wait_cyc(25);
    cap = 1'b0;
    check_frame(8'hA5, 2, "fa5");

    wr(32'h8, 32'h4);
    wr(32'h0, 32'h33);
    acks = 0;
    bus.adr_i = BASE + 32'h4;
    bus.we_i  = 1'b0;
    bus.sel_i = 4'hF;
    bus.stb_i = 1'b1;
    bus.cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
      end
      if (bus.ack_o) begin
        acks++;
        chk("hold_dat", bus.dat_o, 32'h6);
      end else begin
        chk("hold_dat0", bus.dat_o, 32'h0);
      end
    end
    chk("hold_acks", 32'(acks), 32'd1);
    wait_cyc(45);

    wr(32'h0, 32'h11);
    wr(32'h0, 32'h22);
    wr(32'h0, 32'h33);
    wait_cyc(14);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    tx_log.delete();
    cap = 1'b1;
    rd(32'h4);
    chk("midrst_status", r_dat, 32'h2);
    wait_cyc(60);
    cap = 1'b0;
    zeros = 0;
    foreach (tx_log[i]) if (tx_log[i] == 1'b0) zeros++;
    chk("midrst_quiet", 32'(zeros), 32'd0);

    wr(32'h8, 32'h3);
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: xact(BASE, 1'b1, $urandom, 4'($urandom) | 4'h1,
                      $urandom_range(1, 3));
        3: xact(BASE, 1'b1, $urandom, 4'b1110, 1);
        4: xact(BASE + 32'h4, $urandom_range(0, 1), $urandom, 4'hF,
                $urandom_range(1, 3));
        5: xact(BASE + 32'h8 * $urandom_range(0, 1), 1'b0, 32'h0,
                4'hF, 1);
        6: begin
          if (lq.size() == 0 && fq.size() == 0)
            xact(BASE + 32'h8, 1'b1, $urandom_range(0, 5),
                 4'($urandom_range(0, 15)) | 4'h3, 1);
          else wait_cyc(1);
        end
        7: xact(BASE + 32'($urandom_range(1, 15)) | 32'h0, 1'b0,
                32'h0, 4'hF, 1);
        8: xact(32'h4000_2000 + 32'($urandom_range(0, 15)),
                $urandom_range(0, 1), $urandom, 4'hF, 1);
        default: wait_cyc($urandom_range(0, 20));
      endcase
    end
    wait_cyc(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h4000_1000, byte address of the 16-byte register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16'd104, reset value of the baud divisor.
REQ-003 SHALL have one clock; reset is synchronous and active-high, ports clk_i and rst_i.
REQ-004 clk_i  input  1  system clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 stb_i  input  1  Wishbone strobe.
REQ-007 cyc_i  input  1  Wishbone cycle.
REQ-008 adr_i  input  32  Wishbone byte address.
REQ-009 sel_i  input  4  Wishbone byte selects.
REQ-010 dat_i  input  32  write data.
REQ-011 we_i  input  1  write enable.
REQ-012 dat_o  output  32  read data.
REQ-013 ack_o  output  1  cycle complete.
REQ-014 err_o  output  1  cycle error.
REQ-015 rty_o  output  1  cycle retry.
REQ-016 tx_o  output  1  serial line, 8N1, idle high.

Function
REQ-017 Selected = stb_i & cyc_i & adr_i[31:4]==BASE_ADDRESS[31:4]; unselected cycles SHALL produce no response and no state change.
REQ-018 Response SHALL be registered: exactly one of ack_o/err_o/rty_o high for exactly one cycle, the cycle after selection; no response while the previous cycle's response is high (no double response to one held strobe).
REQ-019 dat_o SHALL be 32'h0 except in the cycle a read ack_o is high (OR-combinable with other slaves).
REQ-020 Offset 0x0 DATA: write with sel_i[0]=1 pushes dat_i[7:0] into FIFO and acks; read acks with dat_o=0.
REQ-021 Write to DATA when FIFO full SHALL assert rty_o and not push; sel_i[0]=0 write SHALL ack without push.
REQ-022 Offset 0x4 STATUS (read-only): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), others 0; writes ack, ignored.
REQ-023 Offset 0x8 DIV: bits[15:0] divisor; write needs sel_i[1:0]=2'b11; written values below 2 SHALL be stored as 2; read returns {16'h0, div}.
REQ-024 Offset 0xC and misaligned adr_i[1:0]!=0 SHALL assert err_o, no state change.
REQ-025 FIFO: 4 entries, 2-bit read/write pointers wrapping 3->0, 3-bit count; simultaneous push and pop SHALL keep count unchanged and both occur.
REQ-026 FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty, popping head into shift register same cycle.
REQ-027 START drives tx_o=0, DATA drives shift bits LSB first for bit index 0..7, STOP drives tx_o=1; each bit lasts exactly div cycles.
REQ-028 STOP->START directly if FIFO non-empty at end of stop bit (pop same cycle), else ->IDLE; no idle gap between back-to-back frames.
REQ-029 Frame length SHALL be 10*div cycles; div changes mid-frame take effect at the next bit boundary.
REQ-030 First START cycle SHALL begin the cycle after the push that made FIFO non-empty while IDLE plus one (pop cycle) -- i.e. tx_o falls 2 cycles after the acked write's ack.

Reset
REQ-031 On rst_i: FSM IDLE, FIFO empty, pointers/count 0, div=CLKS_PER_BIT, tx_o=1, ack_o/err_o/rty_o=0, dat_o=0.
REQ-032 Reset mid-frame SHALL abort the frame, tx_o=1 next cycle, discard FIFO contents.

Verification
REQ-033 div=4, write 0x55 to DATA -> ack 1 cycle; tx_o 0(4) then 1,0,1,0,1,0,1,0 (4 each) then 1(4); STATUS bit2 busy then 0.
REQ-034 Five writes of 0x01..0x05 back-to-back while first byte transmitting -> first four ack (one pops immediately), fifth acks; sixth write -> rty_o, STATUS full=1.
REQ-035 Read 0xC and write adr 0x2 -> err_o one cycle, no state change; read unmapped 0x4000_2000 -> no response, dat_o=0.
REQ-036 Write DIV=0 -> read DIV returns 0x0000_0002; frames last 20 cycles.
REQ-037 Assert rst_i during bit 3 of frame with 2 bytes queued -> tx_o=1, STATUS=0x2 (empty), no further frames.
REQ-038 Hold stb_i/cyc_i 3 cycles on STATUS read -> exactly one ack pulse, dat_o non-zero only in ack cycle.
